universal_shift_register: RTL and testbench
===========================================

Name: universal_shift_register

Overview:
- Parametrised successor to the team's 4-bit bidirectional shift register.
- Supports WIDTH-bit parallel load, logical shifts, rotates and arithmetic right shift.
- Each operation is a multi-position shift, started by a one-cycle start strobe.
- Used as the general shift/rotate engine for serial-link and datapath blocks; reports progress with busy and done.

Parameters:
- WIDTH, 8, register width in bits (>=2).
- CNT_W, $clog2(WIDTH)+1, width of the shift-amount input (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  operation request; sampled only in IDLE.
- mode  input  3  operation select, captured at start.
- amount  input  CNT_W  number of single-bit shifts, captured at start.
- load_data  input  WIDTH  parallel-load value.
- serial_right  input  1  bit entering at MSB on logical right shift.
- serial_left  input  1  bit entering at LSB on left shift.
- q  output  WIDTH  register contents.
- serial_out  output  1  last bit shifted or rotated out.
- busy  output  1  high while further shifts remain.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Reset: rst_n low forces q=0, serial_out=0, busy=0, done=0 and state IDLE immediately. This applies mid-operation too; any pending operation is discarded.
- Mode encoding:
  - 000 hold.
  - 001 SRL: q<={serial_right,q[W-1:1]}, out=q[0].
  - 010 SLL: q<={q[W-2:0],serial_left}, out=q[W-1].
  - 011 ROR.
  - 100 ROL.
  - 101 SRA: MSB replicated, out=q[0].
  - 110 parallel load.
  - 111 reserved; behaves as hold.
- Serial inputs are sampled on every shift edge, not only at start.
- States: IDLE, SHIFT, DONE.
- IDLE, start=1, mode 110: q<=load_data at that edge; go to DONE; serial_out unchanged.
- IDLE, start=1, mode 000/111, or any shift mode with amount=0: q unchanged; go to DONE.
- IDLE, start=1, shift mode with amount=N>0:
  - The first shift is performed at the start edge; remaining count = N-1.
  - If N=1, go to DONE; otherwise go to SHIFT.
- SHIFT: one shift per edge and decrement the count; go to DONE after the edge that performs shift N.
- DONE: lasts exactly one cycle, then IDLE. done=1 only in DONE, and q holds its final value during that cycle.
- busy=1 only in SHIFT. busy is high for N-1 cycles; total latency is N edges to the final q.
- start is ignored in SHIFT and DONE. mode, amount and load_data changes after start have no effect.
- amount > WIDTH is legal: exactly N shifts are performed, with no clamping. For example, ROR by WIDTH returns the original value.
- serial_out updates only on shift edges and holds otherwise.

Optional Feature:
- Macro USR_ABORT_EN.
- Defined: adds input port abort (1 bit).
  - abort=1 while in SHIFT: no shift at that edge; go to DONE with q as-is; done pulses normally.
  - abort is ignored in IDLE and DONE.
- Undefined: no abort port; every operation runs to completion.

Test Plan (WIDTH=8):
- Load then reset: load 8'hA5 -> q=A5 after 1 edge, done high for 1 cycle. Start SRL amount=5; drop rst_n after 2 shifts -> q=00, busy=0, done=0, serial_out=0 with no clock edge; start after release works normally.
- q=A5, SRL amount=3, serial_right=0 -> busy high for 2 cycles, then q=8'h14, serial_out=1, done pulse.
- Rotates: q=A5, ROL amount=4 -> q=8'h5A. Load 00, then ROR amount=8 -> q unchanged at 00, serial_out=0.
- SRA: q=8'h85, amount=2 -> q=8'hE1. Also: load 00, SLL amount=8, serial_left=1 -> q=FF after 8 edges; a start pulse at shift 3 with mode 110 is ignored.
- Zero amount and reserved mode: SLL amount=0, then mode 111 -> each gives done on the next cycle, busy never high, q unchanged.
- With USR_ABORT_EN: q=01, SLL amount=6, serial_left=0, abort asserted in the second SHIFT cycle -> q=8'h04, done pulse, then IDLE.

Source files
------------

// File: rtl/universal_shift_register.sv
// -----------------------------------------------------------------------------
// universal_shift_register
//
// Parametrised shift/rotate engine. Each operation is started by a one-cycle
// start strobe in IDLE and performs `amount` single-bit steps, one per clock
// edge. The first step happens on the start edge itself, so an N-step
// operation is finished N edges after start, with busy high in between and a
// one-cycle done pulse once q holds its final value.
//
// Modes (captured at start):
//   000 hold, 001 SRL, 010 SLL, 011 ROR, 100 ROL, 101 SRA,
//   110 parallel load, 111 reserved (hold)
//
// Optional feature: define USR_ABORT_EN to add the `abort` input, which ends
// a running shift early (no step on the aborting edge, done still pulses).
//
// Ports:
//   clk          rising-edge clock
//   rst_n        asynchronous active-low reset
//   start        operation request, sampled only in IDLE
//   mode         operation select (3 bits), captured at start
//   amount       number of single-bit steps (CNT_W bits), captured at start
//   load_data    parallel-load value (WIDTH bits)
//   serial_right bit entering at the MSB on SRL, sampled on every step edge
//   serial_left  bit entering at the LSB on SLL, sampled on every step edge
//   abort        (USR_ABORT_EN only) terminate a running shift
//   q            register contents
//   serial_out   last bit shifted or rotated out
//   busy         high while further steps remain
//   done         one-cycle completion pulse
// -----------------------------------------------------------------------------
module universal_shift_register #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [2:0]       mode,
  input  logic [CNT_W-1:0] amount,
  input  logic [WIDTH-1:0] load_data,
  input  logic             serial_right,
  input  logic             serial_left,
`ifdef USR_ABORT_EN
  input  logic             abort,
`endif
  output logic [WIDTH-1:0] q,
  output logic             serial_out,
  output logic             busy,
  output logic             done
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_DONE
  } state_t;

  typedef enum logic [2:0] {
    M_HOLD = 3'b000,
    M_SRL  = 3'b001,
    M_SLL  = 3'b010,
    M_ROR  = 3'b011,
    M_ROL  = 3'b100,
    M_SRA  = 3'b101,
    M_LOAD = 3'b110,
    M_RSVD = 3'b111
  } mode_t;

  state_t           state;
  mode_t            mode_r;
  logic [CNT_W-1:0] cnt;      // steps still to perform after the current edge

  mode_t            mode_in;
  mode_t            op_mode;
  logic             op_is_shift;
  logic [WIDTH-1:0] step_q;
  logic             step_out;

  assign mode_in = mode_t'(mode);

  // On the start edge the step uses the incoming mode; afterwards the
  // captured copy, so later changes on the mode pins have no effect.
  assign op_mode = (state == S_IDLE) ? mode_in : mode_r;

  assign op_is_shift = (mode_in == M_SRL) || (mode_in == M_SLL) ||
                       (mode_in == M_ROR) || (mode_in == M_ROL) ||
                       (mode_in == M_SRA);

  // One single-bit step of the selected operation.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs; otherwise a
    // mode without a case arm would infer a latch.
    step_q   = q;
    step_out = serial_out;
    unique case (op_mode)
      M_SRL: begin
        step_q   = {serial_right, q[WIDTH-1:1]};
        step_out = q[0];
      end
      M_SLL: begin
        step_q   = {q[WIDTH-2:0], serial_left};
        step_out = q[WIDTH-1];
      end
      M_ROR: begin
        step_q   = {q[0], q[WIDTH-1:1]};
        step_out = q[0];
      end
      M_ROL: begin
        step_q   = {q[WIDTH-2:0], q[WIDTH-1]};
        step_out = q[WIDTH-1];
      end
      M_SRA: begin
        step_q   = {q[WIDTH-1], q[WIDTH-1:1]};
        step_out = q[0];
      end
      default: ;  // hold, load and reserved never step
    endcase
  end

  // NOTE: all state below uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      mode_r     <= M_HOLD;
      cnt        <= '0;
      q          <= '0;
      serial_out <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          busy <= 1'b0;
          done <= 1'b0;
          if (start) begin
            mode_r <= mode_in;
            if (mode_in == M_LOAD) begin
              q     <= load_data;
              state <= S_DONE;
              done  <= 1'b1;
            end else if (op_is_shift && (amount != '0)) begin
              q          <= step_q;
              serial_out <= step_out;
              cnt        <= amount - CNT_W'(1);
              if (amount == CNT_W'(1)) begin
                state <= S_DONE;
                done  <= 1'b1;
              end else begin
                state <= S_SHIFT;
                busy  <= 1'b1;
              end
            end else begin
              // Hold, reserved, or a shift of zero positions.
              state <= S_DONE;
              done  <= 1'b1;
            end
          end
        end

        S_SHIFT: begin
`ifdef USR_ABORT_EN
          if (abort) begin
            state <= S_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else
`endif
          begin
            q          <= step_q;
            serial_out <= step_out;
            cnt        <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
              state <= S_DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end

        S_DONE: begin
          state <= S_IDLE;
          done  <= 1'b0;
          busy  <= 1'b0;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_universal_shift_register.sv
// -----------------------------------------------------------------------------
// tb_universal_shift_register
//
// Self-checking bench for universal_shift_register (WIDTH=8). A behavioural
// model tracks the register value and last bit out, applying each step with
// plain shift/rotate arithmetic on whatever serial inputs were present at the
// edge. Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_universal_shift_register;

  localparam int W  = 8;
  localparam int CW = $clog2(W) + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic [2:0]    mode;
  logic [CW-1:0] amount;
  logic [W-1:0]  load_data;
  logic          serial_right;
  logic          serial_left;
`ifdef USR_ABORT_EN
  logic          abort;
`endif
  logic [W-1:0]  q;
  logic          serial_out;
  logic          busy;
  logic          done;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [W-1:0] m_q;
  logic         m_so;

  always #5 clk = ~clk;

  universal_shift_register #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .mode        (mode),
    .amount      (amount),
    .load_data   (load_data),
    .serial_right(serial_right),
    .serial_left (serial_left),
`ifdef USR_ABORT_EN
    .abort       (abort),
`endif
    .q           (q),
    .serial_out  (serial_out),
    .busy        (busy),
    .done        (done)
  );

  // One step of a shift mode, computed with whole-word arithmetic.
  function automatic void model_step(input logic [2:0] m, input logic sr, input logic sl);
    logic [2*W-1:0] dbl;
    dbl = {m_q, m_q};
    case (m)
      3'd1: begin m_so = m_q[0];   m_q = (m_q >> 1) | (W'(sr) << (W-1)); end
      3'd2: begin m_so = m_q[W-1]; m_q = (m_q << 1) | W'(sl); end
      3'd3: begin m_so = m_q[0];   dbl = dbl >> 1; m_q = dbl[W-1:0]; end
      3'd4: begin m_so = m_q[W-1]; dbl = dbl << 1; m_q = dbl[2*W-1:W]; end
      3'd5: begin m_so = m_q[0];   m_q = W'($signed(m_q) >>> 1); end
      default: ;
    endcase
  endfunction

  // Runs one complete operation, checking q/serial_out/busy/done every cycle
  // from the start edge until one cycle after the done pulse.
  //   spur_at : step index after which a spurious load start is pulsed (-1 none)
  //   abort_at: SHIFT cycle (1-based) in which abort is raised (-1 none)
  task automatic run_op(input string name, input logic [2:0] m, input int n,
                        input logic [W-1:0] ld, input logic sr0, input logic sl0,
                        input bit rnd_ser, input int spur_at, input int abort_at);
    bit           is_shift;
    int           edges;
    logic [W+2:0] obs;
    logic [W+2:0] exp;
    is_shift     = (m >= 3'd1) && (m <= 3'd5) && (n > 0);
    start        = 1'b1;
    mode         = m;
    amount       = CW'(n);
    load_data    = ld;
    serial_right = rnd_ser ? 1'($urandom_range(0, 1)) : sr0;
    serial_left  = rnd_ser ? 1'($urandom_range(0, 1)) : sl0;
    @(posedge clk);
    if (m == 3'd6) m_q = ld;
    else if (is_shift) model_step(m, serial_right, serial_left);
    @(negedge clk);
    // Scramble the captured inputs; the operation must not notice.
    start     = 1'b0;
    mode      = 3'($urandom);
    amount    = CW'($urandom);
    load_data = W'($urandom);
    edges     = 1;
    while (is_shift && edges < n) begin
      obs = {q, serial_out, busy, done};
      exp = {m_q, m_so, 1'b1, 1'b0};
      total++;
      if (obs !== exp) begin
        bad++;
        $display("FAIL %s busy_phase step=%0d: got q=%h so=%b busy=%b done=%b, want q=%h so=%b busy=1 done=0",
                 name, edges, q, serial_out, busy, done, m_q, m_so);
      end
      if (rnd_ser) begin
        serial_right = 1'($urandom_range(0, 1));
        serial_left  = 1'($urandom_range(0, 1));
      end
      if (edges == spur_at) begin
        start = 1'b1;
        mode  = 3'd6;
      end
`ifdef USR_ABORT_EN
      if (edges == abort_at) abort = 1'b1;
`endif
      @(posedge clk);
`ifdef USR_ABORT_EN
      if (abort) begin
        @(negedge clk);
        abort = 1'b0;
        start = 1'b0;
        break;
      end
`endif
      model_step(m, serial_right, serial_left);
      edges++;
      @(negedge clk);
      start = 1'b0;
      mode  = 3'($urandom);
    end
    obs = {q, serial_out, busy, done};
    exp = {m_q, m_so, 1'b0, 1'b1};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s done_phase: got q=%h so=%b busy=%b done=%b, want q=%h so=%b busy=0 done=1",
               name, q, serial_out, busy, done, m_q, m_so);
    end
    @(posedge clk);
    @(negedge clk);
    obs = {q, serial_out, busy, done};
    exp = {m_q, m_so, 1'b0, 1'b0};
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s idle_after: got q=%h so=%b busy=%b done=%b, want q=%h so=%b busy=0 done=0",
               name, q, serial_out, busy, done, m_q, m_so);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    total++;
    if ({q, serial_out, busy, done} !== {W'(0), 3'b000}) begin
      bad++;
      $display("FAIL reset_initial: got q=%h so=%b busy=%b done=%b, want all zero", q, serial_out, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_q   = '0;
    m_so  = 1'b0;
    run_op("load_a5", 3'd6, 0, 8'hA5, 1'b0, 1'b0, 1'b0, -1, -1);
    total++;
    if (q !== 8'hA5) begin
      bad++;
      $display("FAIL load_a5_value: got q=%h, want a5", q);
    end
    // SRL by 5, interrupted by reset after two steps.
    start        = 1'b1;
    mode         = 3'd1;
    amount       = CW'(5);
    serial_right = 1'b0;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk);
    #2;
    total++;
    if ({q, busy} !== {8'h29, 1'b1}) begin
      bad++;
      $display("FAIL srl_before_reset: got q=%h busy=%b, want q=29 busy=1", q, busy);
    end
    rst_n = 1'b0;
    #1;
    total++;
    if ({q, serial_out, busy, done} !== {W'(0), 3'b000}) begin
      bad++;
      $display("FAIL reset_mid_op: got q=%h so=%b busy=%b done=%b, want all zero", q, serial_out, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    m_q   = '0;
    m_so  = 1'b0;
    run_op("sll_after_reset", 3'd2, 3, 8'h00, 1'b0, 1'b1, 1'b0, -1, -1);
    total++;
    if (q !== 8'h07) begin
      bad++;
      $display("FAIL sll_after_reset_value: got q=%h, want 07", q);
    end
  endtask

  task automatic test_srl();
    run_op("load_a5_b", 3'd6, 0, 8'hA5, 1'b0, 1'b0, 1'b0, -1, -1);
    run_op("srl3", 3'd1, 3, 8'h00, 1'b0, 1'b0, 1'b0, -1, -1);
    total++;
    if ({q, serial_out} !== {8'h14, 1'b1}) begin
      bad++;
      $display("FAIL srl3_value: got q=%h so=%b, want q=14 so=1", q, serial_out);
    end
  endtask

  task automatic test_rotate();
    run_op("load_a5_c", 3'd6, 0, 8'hA5, 1'b0, 1'b0, 1'b0, -1, -1);
    run_op("rol4", 3'd4, 4, 8'h00, 1'b0, 1'b0, 1'b0, -1, -1);
    total++;
    if (q !== 8'h5A) begin
      bad++;
      $display("FAIL rol4_value: got q=%h, want 5a", q);
    end
    run_op("load_00", 3'd6, 0, 8'h00, 1'b0, 1'b0, 1'b0, -1, -1);
    run_op("ror8", 3'd3, 8, 8'h00, 1'b1, 1'b1, 1'b0, -1, -1);
    total++;
    if ({q, serial_out} !== {8'h00, 1'b0}) begin
      bad++;
      $display("FAIL ror8_value: got q=%h so=%b, want q=00 so=0", q, serial_out);
    end
    run_op("load_c3", 3'd6, 0, 8'hC3, 1'b0, 1'b0, 1'b0, -1, -1);
    run_op("ror11", 3'd3, 11, 8'h00, 1'b0, 1'b0, 1'b0, -1, -1);
    total++;
    if (q !== 8'h78) begin
      bad++;
      $display("FAIL ror11_value: got q=%h, want 78", q);
    end
  endtask

  task automatic test_sra();
    run_op("load_85", 3'd6, 0, 8'h85, 1'b0, 1'b0, 1'b0, -1, -1);
    run_op("sra2", 3'd5, 2, 8'h00, 1'b0, 1'b0, 1'b0, -1, -1);
    total++;
    if (q !== 8'hE1) begin
      bad++;
      $display("FAIL sra2_value: got q=%h, want e1", q);
    end
  endtask

  task automatic test_sll_fill();
    run_op("load_00_b", 3'd6, 0, 8'h00, 1'b0, 1'b0, 1'b0, -1, -1);
    run_op("sll8_fill", 3'd2, 8, 8'h00, 1'b0, 1'b1, 1'b0, 3, -1);
    total++;
    if (q !== 8'hFF) begin
      bad++;
      $display("FAIL sll8_fill_value: got q=%h, want ff", q);
    end
  endtask

  task automatic test_zero_reserved();
    run_op("load_3c", 3'd6, 0, 8'h3C, 1'b0, 1'b0, 1'b0, -1, -1);
    run_op("sll0", 3'd2, 0, 8'h00, 1'b0, 1'b1, 1'b0, -1, -1);
    run_op("reserved", 3'd7, 5, 8'hFF, 1'b1, 1'b1, 1'b0, -1, -1);
    run_op("hold", 3'd0, 3, 8'hFF, 1'b1, 1'b1, 1'b0, -1, -1);
    total++;
    if (q !== 8'h3C) begin
      bad++;
      $display("FAIL zero_reserved_value: got q=%h, want 3c", q);
    end
  endtask

`ifdef USR_ABORT_EN
  task automatic test_abort();
    run_op("load_01", 3'd6, 0, 8'h01, 1'b0, 1'b0, 1'b0, -1, -1);
    run_op("sll6_abort", 3'd2, 6, 8'h00, 1'b0, 1'b0, 1'b0, -1, 2);
    total++;
    if (q !== 8'h04) begin
      bad++;
      $display("FAIL sll6_abort_value: got q=%h, want 04", q);
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 40; i++) begin
      run_op("random", 3'($urandom_range(0, 7)), int'($urandom_range(0, 12)),
             W'($urandom), 1'b0, 1'b0, 1'b1, -1, -1);
    end
  endtask

  initial begin
    start        = 1'b0;
    mode         = 3'd0;
    amount       = '0;
    load_data    = '0;
    serial_right = 1'b0;
    serial_left  = 1'b0;
`ifdef USR_ABORT_EN
    abort        = 1'b0;
`endif
    test_reset();
    test_srl();
    test_rotate();
    test_sra();
    test_sll_fill();
    test_zero_reserved();
`ifdef USR_ABORT_EN
    test_abort();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
